// File: rtl/packed_field_arbiter.sv
// Round-robin arbiter sharing one packed {x,y,z} status register among NUM_REQ writers.
// Optional parity self-check enabled by defining PACKED_FIELD_ARB_PARITY_EN.

module pfa_field #(
  parameter int W = 1
)(
  input  logic [W-1:0] cur,
  input  logic [W-1:0] wdata,
  input  logic         we,
  output logic [W-1:0] nxt
);
  assign nxt = we ? wdata : cur;
endmodule

module packed_field_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int FIELD_W  = 1,
  parameter int MAX_HOLD = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [3*NUM_REQ-1:0]           req_wmask,
  input  logic [3*FIELD_W*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ID_W-1:0]                grant_id,
  output logic                           busy,
  output logic [3*FIELD_W-1:0]           st_packed,
  output logic [FIELD_W-1:0]             st_x,
  output logic [FIELD_W-1:0]             st_y,
  output logic [FIELD_W-1:0]             st_z
`ifdef PACKED_FIELD_ARB_PARITY_EN
  ,
  output logic                           st_parity,
  output logic                           parity_err
`endif
);
  localparam int HC_W = $clog2(MAX_HOLD) + 1;
  localparam int SW   = 3*FIELD_W;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t          state, state_n;
  logic [ID_W-1:0] ptr, ptr_n, owner, owner_n, owner_inc, win;
  logic [HC_W-1:0] hold, hold_n;
  logic            xfer;
  logic [2:0]      wm [NUM_REQ];
  logic [SW-1:0]   wd [NUM_REQ];
  logic [2:0]      wm_o;
  logic [SW-1:0]   wd_o, st_n;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign wm[g] = req_wmask[3*g +: 3];
    assign wd[g] = req_wdata[SW*g +: SW];
  end

  assign wm_o = wm[owner];
  assign wd_o = wd[owner];

  // Mask bit f guards field slice f, so bit2 lands on x in the MSBs.
  for (genvar f = 0; f < 3; f++) begin : g_fld
    pfa_field #(.W(FIELD_W)) u_fld (
      .cur   (st_packed[f*FIELD_W +: FIELD_W]),
      .wdata (wd_o[f*FIELD_W +: FIELD_W]),
      .we    (xfer & wm_o[f]),
      .nxt   (st_n[f*FIELD_W +: FIELD_W])
    );
  end

  // Scan downward so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin : arb
    logic [ID_W:0] idx;
    win = '0;
    idx = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (req_valid[idx[ID_W-1:0]]) win = idx[ID_W-1:0];
    end
  end

  assign owner_inc = (owner == ID_W'(NUM_REQ-1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      hold      <= '0;
      st_packed <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      owner     <= owner_n;
      hold      <= hold_n;
      st_packed <= st_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    hold_n  = hold;
    xfer    = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_n = OWNED;
          owner_n = win;
          hold_n  = '0;
        end
      end
      OWNED: begin
        xfer = req_valid[owner];
        // Dropping valid releases exactly like an unlocked transfer, minus the write.
        if (!req_valid[owner] || !req_lock[owner] || hold == HC_W'(MAX_HOLD-1)) begin
          state_n = IDLE;
          ptr_n   = owner_inc;
        end else begin
          hold_n  = hold + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == OWNED) req_ready[owner] = 1'b1;
  end

  assign busy     = (state == OWNED);
  assign grant_id = owner;
  assign st_x     = st_packed[2*FIELD_W +: FIELD_W];
  assign st_y     = st_packed[FIELD_W +: FIELD_W];
  assign st_z     = st_packed[0 +: FIELD_W];

`ifdef PACKED_FIELD_ARB_PARITY_EN
  logic [SW-1:0] fmask;
  for (genvar f = 0; f < 3; f++) begin : g_pmask
    assign fmask[f*FIELD_W +: FIELD_W] = {FIELD_W{wm_o[f]}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_parity  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      st_parity  <= ^st_n;
      parity_err <= xfer && ((^(st_n & fmask)) != (^(wd_o & fmask)));
    end
  end
`endif

endmodule

// File: tb/tb_packed_field_arbiter.sv
// Scoreboard bench for packed_field_arbiter: writes are queued as stimulus is driven
// and popped when the DUT completes a handshake.
module tb_packed_field_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0, req_lock = '0;
  logic [3*N-1:0] req_wmask = '0, req_wdata = '0;
  logic [N-1:0]  req_ready;
  logic [1:0]    grant_id;
  logic          busy;
  logic [2:0]    st_packed;
  logic          st_x, st_y, st_z;
`ifdef PACKED_FIELD_ARB_PARITY_EN
  logic          st_parity, parity_err;
`endif

  int n_cmp = 0, n_bad = 0;
  logic [2:0] exp_q [$];
  logic [2:0] model_st = '0;
  logic [2:0] sb_e;
  logic       fire = 1'b0;

  packed_field_arbiter #(.NUM_REQ(N), .FIELD_W(1), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_lock(req_lock),
    .req_wmask(req_wmask), .req_wdata(req_wdata),
    .req_ready(req_ready), .grant_id(grant_id), .busy(busy),
    .st_packed(st_packed), .st_x(st_x), .st_y(st_y), .st_z(st_z)
`ifdef PACKED_FIELD_ARB_PARITY_EN
    , .st_parity(st_parity), .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Handshake monitor: inputs change just after posedge, so negedge sampling sees edge values.
  always @(negedge clk) fire = rst_n && busy && req_valid[grant_id];

  always @(posedge clk) begin
    #1;
    if (fire) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++; $display("FAIL sb_unexpected_write: got st=%b want no write", st_packed);
      end else begin
        sb_e = exp_q.pop_front();
        if (st_packed !== sb_e) begin n_bad++; $display("FAIL sb_write: got %b want %b", st_packed, sb_e); end
      end
      n_cmp++;
      if ({st_x, st_y, st_z} !== st_packed) begin n_bad++; $display("FAIL sb_views: got %b want %b", {st_x, st_y, st_z}, st_packed); end
`ifdef PACKED_FIELD_ARB_PARITY_EN
      n_cmp++;
      if (st_parity !== ^st_packed) begin n_bad++; $display("FAIL sb_parity: got %b want %b", st_parity, ^st_packed); end
`endif
    end
`ifdef PACKED_FIELD_ARB_PARITY_EN
    if (rst_n && parity_err !== 1'b0) begin n_cmp++; n_bad++; $display("FAIL parity_err: got %b want 0", parity_err); end
`endif
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [2:0] m, input logic [2:0] d);
    req_valid[i] = v; req_lock[i] = l;
    req_wmask[3*i +: 3] = m; req_wdata[3*i +: 3] = d;
  endtask

  // Apply requester i's currently driven mask/data to the model and queue the result.
  task automatic push_write(input int i);
    logic [2:0] m, d;
    m = req_wmask[3*i +: 3]; d = req_wdata[3*i +: 3];
    model_st = (model_st & ~m) | (d & m);
    exp_q.push_back(model_st);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 3'b111, 3'b110);
    repeat (2) begin
      tick;
      n_cmp++; if (st_packed !== 3'b000) begin n_bad++; $display("FAIL rst_st: got %b want 000", st_packed); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL rst_gid: got %0d want 0", grant_id); end
    end
    rst_n = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_rel_ready: got %b want 0000", req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_rel_busy: got %b want 0", busy); end
    model_st = 3'b000;
    push_write(0);
    tick;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rst_grant_ready: got %b want 0001", req_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_grant_busy: got %b want 1", busy); end
    req_valid = 4'b0001;
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_xfer_busy: got %b want 0", busy); end
    n_cmp++; if (st_packed !== 3'b110) begin n_bad++; $display("FAIL rst_xfer_st: got %b want 110", st_packed); end
    req_valid = '0;
    tick;
  endtask

  task automatic test_single;
    rst_n = 1'b0; tick; rst_n = 1'b1; model_st = 3'b000;
    req_valid = '0;
    set_req(1, 1'b1, 1'b0, 3'b101, 3'b111);
    tick;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL single_ready: got %b want 0010", req_ready); end
    n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL single_gid: got %0d want 1", grant_id); end
    n_cmp++; if (st_packed !== 3'b000) begin n_bad++; $display("FAIL single_st_early: got %b want 000", st_packed); end
    push_write(1);
    tick;
    n_cmp++; if (st_packed !== 3'b101) begin n_bad++; $display("FAIL single_st: got %b want 101", st_packed); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL single_idle_ready: got %b want 0000", req_ready); end
    // ptr should now be 2: with 1 and 3 pending, 3 wins.
    set_req(3, 1'b1, 1'b0, 3'b000, 3'b000);
    tick;
    n_cmp++; if (grant_id !== 2'd3) begin n_bad++; $display("FAIL single_ptr_gid: got %0d want 3", grant_id); end
    req_valid = '0;
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_drop_busy: got %b want 0", busy); end
    n_cmp++; if (st_packed !== 3'b101) begin n_bad++; $display("FAIL single_drop_st: got %b want 101", st_packed); end
  endtask

  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    set_req(0, 1'b1, 1'b0, 3'b111, 3'b001);
    set_req(1, 1'b1, 1'b0, 3'b010, 3'b111);
    set_req(2, 1'b1, 1'b0, 3'b100, 3'b100);
    set_req(3, 1'b1, 1'b0, 3'b011, 3'b010);
    for (int k = 0; k < 5; k++) push_write(order[k]);
    for (int k = 0; k < 5; k++) begin
      tick;
      n_cmp++; if (req_ready !== 4'(1 << order[k])) begin n_bad++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, 4'(1 << order[k])); end
      n_cmp++; if (grant_id !== 2'(order[k])) begin n_bad++; $display("FAIL rr_gid[%0d]: got %0d want %0d", k, grant_id, order[k]); end
      tick;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rr_gap[%0d]: got busy %b want 0", k, busy); end
      if (k == 4) req_valid = '0;
    end
  endtask

  task automatic test_lock_limit;
    logic [2:0] vals [4] = '{3'b011, 3'b100, 3'b010, 3'b111};
    req_valid = '0; req_lock = '0;
    set_req(2, 1'b1, 1'b1, 3'b111, 3'b000);
    set_req(3, 1'b1, 1'b0, 3'b010, 3'b000);
    tick;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL lock_grant: got %b want 0100", req_ready); end
    for (int k = 0; k < 4; k++) begin
      req_wdata[8:6] = vals[k];
      push_write(2);
      tick;
      if (k < 3) begin
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL lock_hold[%0d]: got %b want 0100", k, req_ready); end
      end else begin
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL lock_release: got %b want 0000", req_ready); end
      end
    end
    tick;
    n_cmp++; if (grant_id !== 2'd3) begin n_bad++; $display("FAIL lock_next_gid: got %0d want 3", grant_id); end
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL lock_next_ready: got %b want 1000", req_ready); end
    push_write(3);
    req_valid = 4'b1000;
    tick;
    n_cmp++; if (st_packed !== 3'b101) begin n_bad++; $display("FAIL lock_next_st: got %b want 101", st_packed); end
    req_valid = '0; req_lock = '0;
  endtask

  task automatic test_owner_drop;
    set_req(0, 1'b1, 1'b0, 3'b111, 3'b000);
    set_req(1, 1'b1, 1'b0, 3'b001, 3'b000);
    tick;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL drop_grant: got %b want 0001", req_ready); end
    req_valid[0] = 1'b0;
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drop_idle: got busy %b want 0", busy); end
    n_cmp++; if (st_packed !== 3'b101) begin n_bad++; $display("FAIL drop_nowrite: got %b want 101", st_packed); end
    tick;
    n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL drop_next_gid: got %0d want 1", grant_id); end
    push_write(1);
    tick;
    n_cmp++; if (st_packed !== 3'b100) begin n_bad++; $display("FAIL drop_next_st: got %b want 100", st_packed); end
    req_valid = '0;
  endtask

  task automatic test_reset_midlock;
    set_req(2, 1'b1, 1'b1, 3'b111, 3'b011);
    tick;
    n_cmp++; if (grant_id !== 2'd2) begin n_bad++; $display("FAIL rml_gid: got %0d want 2", grant_id); end
    push_write(2);
    tick;
    req_wdata[8:6] = 3'b110;
    push_write(2);
    tick;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rml_held: got busy %b want 1", busy); end
    rst_n = 1'b0;
    tick;
    model_st = 3'b000;
    n_cmp++; if (st_packed !== 3'b000) begin n_bad++; $display("FAIL rml_st: got %b want 000", st_packed); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rml_busy: got %b want 0", busy); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rml_ready: got %b want 0000", req_ready); end
    rst_n = 1'b1;
    req_lock = '0;
    req_valid = 4'b0110;
    tick;
    n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL rml_ptr_gid: got %0d want 1", grant_id); end
    req_valid = '0;
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rml_end_busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_lock_limit;
    test_owner_drop;
    test_reset_midlock;
    tick;
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL sb_drain: got %0d pending want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/packed_field_arbiter.md
Name: packed_field_arbiter

Overview:
- Shares one packed status register {x, y, z} between NUM_REQ writers.
- Round-robin arbitration with optional multi-cycle ownership (lock), per-field write masks, and a bounded hold time.
- Drives the packed register and its unpacked field views to downstream consumers.
- Sits between the requester blocks and every reader of the x/y/z state.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FIELD_W, 1, width of each of x, y, z.
- MAX_HOLD, 4, maximum consecutive locked transfers per grant (>=1).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_lock  in  NUM_REQ  requester asks to keep ownership after the current transfer.
- req_wmask  in  3*NUM_REQ  per requester; bit2=x, bit1=y, bit0=z; slice i = [3i +: 3].
- req_wdata  in  3*FIELD_W*NUM_REQ  per requester {x,y,z}, x in the MSBs; slice i = [3*FIELD_W*i +: 3*FIELD_W].
- req_ready  out  NUM_REQ  one-hot grant; all zero when IDLE.
- grant_id  out  clog2(NUM_REQ) (min 1)  current owner index.
- busy  out  1  high while in OWNED.
- st_packed  out  3*FIELD_W  {x,y,z} register.
- st_x, st_y, st_z  out  FIELD_W each  unpacked field views of st_packed, purely combinational slices.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, rr pointer=0, st_packed=0, req_ready=0, grant_id=0, busy=0, hold_cnt=0.
  - Reset mid-transfer discards that transfer; the register is cleared regardless of any valid/ready.
- States: IDLE, OWNED.
- IDLE:
  - If any req_valid is high, winner = first valid index at or after ptr, scanning upward with wrap.
  - Next state OWNED, owner=winner, hold_cnt=0.
  - With no valid requests, stay in IDLE.
- OWNED:
  - req_ready[owner]=1, all other ready bits 0; busy=1; grant_id=owner. All are registered outputs.
  - A transfer occurs when req_valid[owner] && req_ready[owner]. At that edge, each field with its mask bit set takes the owner's wdata slice; unmasked fields hold.
  - A mask of 000 still counts as a transfer and leaves the register unchanged.
  - Transfer with req_lock[owner]=1 and hold_cnt < MAX_HOLD-1: stay in OWNED, hold_cnt++.
  - Transfer with req_lock[owner]=0, or hold_cnt == MAX_HOLD-1: go to IDLE, ptr = (owner+1) mod NUM_REQ.
  - req_valid[owner]=0 while OWNED: release to IDLE with no write; ptr advances the same way.
- Latency and throughput:
  - Request in IDLE → ready on the next cycle; the write is visible on st_* the cycle after the transfer edge.
  - Unlocked traffic: one transfer per 2 cycles.
  - Locked traffic: up to MAX_HOLD back-to-back transfers per grant.
- Simultaneous events:
  - Other requesters' valid while OWNED are ignored; they are not lost and remain pending for arbitration.
  - A request from the releasing owner competes in the next IDLE arbitration at lowest priority (ptr has moved past it).
- Inputs of non-owners never affect state or data.
- Arithmetic: ptr wraps modulo NUM_REQ, including non-power-of-two values. hold_cnt is clog2(MAX_HOLD)+1 bits and never wraps.

Optional Feature:
- Macro: PACKED_FIELD_ARB_PARITY_EN.
- When defined:
  - Adds output st_parity (1 bit) = XOR of all bits of st_packed, registered and updated at the same edge as st_packed; reset value 0.
  - Adds output parity_err (1 bit), registered, which pulses for one cycle if a transfer writes a value whose XOR differs from the owner's req_wdata XOR over the masked fields. This is a self-check and must never fire in correct RTL.
- When undefined: neither port exists and no parity logic is built.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with all valid=1 → st_packed=0, req_ready=0, busy=0, grant_id=0 throughout and one cycle after release; grant occurs on the following edge.
- Single writer: req 1 valid, mask=101, wdata=111 (FIELD_W=1), prior state 000 → ready[1] on cycle+1, st_packed=101 on cycle+2, ptr=2, IDLE.
- Round-robin fairness: all 4 requesters constantly valid and unlocked → grant order 0,1,2,3,0, each grant 2 cycles apart.
- Lock limit: req 2 valid with lock=1 held, MAX_HOLD=4 → exactly 4 consecutive ready cycles, then IDLE; next grant goes to req 3 if it is valid.
- Owner drops valid: grant req 0, deassert valid[0] before the transfer → no write, IDLE next cycle, req 1 granted next.
- Reset mid-lock: during locked hold_cnt=2, assert rst_n=0 → st_packed=0, state IDLE, ptr=0 on that edge.
